// File: rtl/mips_ex_pkg.sv
// Shared types for the MIPS execute stage.
// ALU control, function codes and mul/div op encodings.
package mips_ex_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLLV, ALU_SRLV, ALU_SRAV,
    ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO,
    ALU_MD_START, ALU_NOP
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

endpackage

// File: rtl/ex_stage_md_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Works on magnitudes; signs are applied on the final cycle.
module muldiv_iter
  import mips_ex_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(MD_CYCLES + 1);
  localparam logic [CW-1:0] XL = CW'(XLEN);

  typedef enum logic {IDLE, BUSY} st_e;

  st_e             st, st_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc_hi, acc_lo, mcand, a_q;
  logic            is_div, neg_q, rneg_q, dz_q;

  logic            sa, sb, sgn;
  logic [XLEN-1:0] ma, mb;
  logic [XLEN:0]   mul_sum, sh;
  logic [XLEN+1:0] diff;
  logic            ge, stepping;
  logic [XLEN-1:0] nxt_hi, nxt_lo;
  logic [2*XLEN-1:0] prod;

  assign sgn = (op == MD_MULT) || (op == MD_DIV);
  assign sa  = sgn & a[XLEN-1];
  assign sb  = sgn & b[XLEN-1];
  assign ma  = sa ? -a : a;
  assign mb  = sb ? -b : b;

  assign busy = (st == BUSY);
  assign done = busy && (cnt == CW'(1));
  // The last XLEN busy cycles carry the iteration; any extra cycles idle first.
  assign stepping = busy && (cnt <= XL);

  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    sh      = {acc_hi, acc_lo[XLEN-1]};
    diff    = {1'b0, sh} - {2'b0, mcand};
    ge      = !diff[XLEN+1];
    nxt_hi  = acc_hi;
    nxt_lo  = acc_lo;
    if (stepping && !is_div) begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end else if (stepping) begin
      nxt_hi = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
      nxt_lo = {acc_lo[XLEN-2:0], ge};
    end
  end

  always_comb begin
    prod = {nxt_hi, nxt_lo};
    if (neg_q) prod = -prod;
    hi = prod[2*XLEN-1:XLEN];
    lo = prod[XLEN-1:0];
    if (is_div && dz_q) begin
      hi = a_q;
      lo = '1;
    end else if (is_div) begin
      hi = rneg_q ? -nxt_hi : nxt_hi;
      lo = neg_q ? -nxt_lo : nxt_lo;
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE: if (start) st_nxt = BUSY;
      BUSY: if (done) st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      a_q    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st == IDLE && start) begin
        cnt    <= CW'(MD_CYCLES);
        acc_hi <= '0;
        acc_lo <= ma;
        mcand  <= mb;
        a_q    <= a;
        is_div <= op[1];
        neg_q  <= sa ^ sb;
        rneg_q <= sa;
        dz_q   <= (b == '0);
      end else if (busy) begin
        cnt    <= cnt - CW'(1);
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
      end
    end
  end

endmodule

// File: rtl/ex_stage_md.sv
// MIPS execute stage: ALU-control decode, registered ALU,
// HI/LO registers and an iterative multiply/divide unit.
module ex_stage_md
  import mips_ex_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [XLEN-1:0] immediate_ext,
  input  logic            ALUSrc,
  input  logic [1:0]      ALUOp,
  input  logic [5:0]      funct,
  output logic            out_valid,
  output logic [XLEN-1:0] aluOut,
  output logic            zeroFlag,
  output logic            md_busy
);

  localparam int SW = $clog2(XLEN);

  alu_ctrl_e       ctrl;
  logic [XLEN-1:0] op_b, res, hi_q, lo_q;
  logic [XLEN-1:0] md_hi, md_lo;
  logic [SW-1:0]   shamt;
  logic            accept, md_start, md_done;

  assign in_ready = !md_busy;
  assign accept   = in_valid & in_ready & !flush;
  assign op_b     = ALUSrc ? immediate_ext : srcB;
  assign shamt    = srcA[SW-1:0];
  assign md_start = accept && (ctrl == ALU_MD_START);

  always_comb begin
    ctrl = ALU_NOP;
    unique case (ALUOp)
      2'b00: ctrl = ALU_ADD;
      2'b01: ctrl = ALU_SUB;
      2'b11: ctrl = ALU_OR;
      2'b10: begin
        case (funct)
          F_ADD, F_ADDU: ctrl = ALU_ADD;
          F_SUB, F_SUBU: ctrl = ALU_SUB;
          F_AND:  ctrl = ALU_AND;
          F_OR:   ctrl = ALU_OR;
          F_XOR:  ctrl = ALU_XOR;
          F_NOR:  ctrl = ALU_NOR;
          F_SLT:  ctrl = ALU_SLT;
          F_SLTU: ctrl = ALU_SLTU;
          F_SLLV: ctrl = ALU_SLLV;
          F_SRLV: ctrl = ALU_SRLV;
          F_SRAV: ctrl = ALU_SRAV;
          F_MFHI: ctrl = ALU_MFHI;
          F_MFLO: ctrl = ALU_MFLO;
          F_MTHI: ctrl = ALU_MTHI;
          F_MTLO: ctrl = ALU_MTLO;
          F_MULT, F_MULTU,
          F_DIV, F_DIVU: ctrl = ALU_MD_START;
          default: ctrl = ALU_NOP;
        endcase
      end
    endcase
  end

  always_comb begin
    res = '0;
    case (ctrl)
      ALU_ADD:  res = srcA + op_b;
      ALU_SUB:  res = srcA - op_b;
      ALU_AND:  res = srcA & op_b;
      ALU_OR:   res = srcA | op_b;
      ALU_XOR:  res = srcA ^ op_b;
      ALU_NOR:  res = ~(srcA | op_b);
      ALU_SLT:  res = XLEN'($signed(srcA) < $signed(op_b));
      ALU_SLTU: res = XLEN'(srcA < op_b);
      ALU_SLLV: res = op_b << shamt;
      ALU_SRLV: res = op_b >> shamt;
      ALU_SRAV: res = $signed(op_b) >>> shamt;
      ALU_MFHI: res = hi_q;
      ALU_MFLO: res = lo_q;
      default:  res = '0;
    endcase
  end

  muldiv_iter #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (md_op_e'(funct[1:0])),
    .a     (srcA),
    .b     (srcB),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      aluOut    <= '0;
      zeroFlag  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        aluOut   <= res;
        zeroFlag <= (res == '0);
      end
      // mthi/mtlo cannot be accepted while the unit is busy, so no clash with done.
      if (md_done) begin
        hi_q <= md_hi;
        lo_q <= md_lo;
      end else if (accept) begin
        if (ctrl == ALU_MTHI) hi_q <= srcA;
        if (ctrl == ALU_MTLO) lo_q <= srcA;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: ALU ops, mul/div, stalls,
// flush, mid-operation reset and a 16-bit instance.
module tb_ex_stage_md;
  import mips_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, ALUSrc;
  logic [31:0] srcA, srcB, imm;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic        out_valid, zeroFlag, md_busy;
  logic [31:0] aluOut;

  logic        s_in_valid, s_in_ready, s_ALUSrc;
  logic [15:0] s_srcA, s_srcB, s_imm;
  logic [1:0]  s_ALUOp;
  logic [5:0]  s_funct;
  logic        s_out_valid, s_zeroFlag, s_md_busy;
  logic [15:0] s_aluOut;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage_md #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .srcA(srcA), .srcB(srcB),
    .immediate_ext(imm), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .funct(funct),
    .out_valid(out_valid), .aluOut(aluOut),
    .zeroFlag(zeroFlag), .md_busy(md_busy)
  );

  ex_stage_md #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .srcA(s_srcA), .srcB(s_srcB),
    .immediate_ext(s_imm), .ALUSrc(s_ALUSrc),
    .ALUOp(s_ALUOp), .funct(s_funct),
    .out_valid(s_out_valid), .aluOut(s_aluOut),
    .zeroFlag(s_zeroFlag), .md_busy(s_md_busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [1:0] aop,
                    input logic [5:0] fn,
                    input logic [31:0] a, b, im,
                    input logic src, fl);
    @(negedge clk);
    ALUOp = aop; funct = fn; srcA = a; srcB = b;
    imm = im; ALUSrc = src; flush = fl;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic rop(input logic [5:0] fn,
                     input logic [31:0] a, b);
    op(2'b10, fn, a, b, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic op16(input logic [5:0] fn,
                      input logic [15:0] a, b);
    @(negedge clk);
    s_ALUOp = 2'b10; s_funct = fn;
    s_srcA = a; s_srcB = b;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  aop;
    logic [5:0]  fn;
    logic [31:0] a, b, im;
    logic        src;
    logic [31:0] exp;
  } vec_t;

  vec_t v[15];
  int   n;

  initial begin
    v[0]  = '{2'b10, F_ADD,  32'd5, 32'd7, 32'h0, 1'b0, 32'd12};
    v[1]  = '{2'b01, 6'h00,  32'h1234, 32'h1234, 32'h0, 1'b0, 32'h0};
    v[2]  = '{2'b00, 6'h00,  32'd8, 32'h99, 32'hFFFFFFFC, 1'b1, 32'd4};
    v[3]  = '{2'b10, F_AND,  32'hF0F0, 32'hFF00, 32'h0, 1'b0, 32'hF000};
    v[4]  = '{2'b10, F_OR,   32'hF0F0, 32'hFF00, 32'h0, 1'b0, 32'hFFF0};
    v[5]  = '{2'b10, F_XOR,  32'hF0F0, 32'hFF00, 32'h0, 1'b0, 32'h0FF0};
    v[6]  = '{2'b10, F_NOR,  32'h0, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF};
    v[7]  = '{2'b10, F_SLT,  32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 32'd1};
    v[8]  = '{2'b10, F_SLTU, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 32'd0};
    v[9]  = '{2'b10, F_SLLV, 32'd4, 32'd1, 32'h0, 1'b0, 32'd16};
    v[10] = '{2'b10, F_SRLV, 32'd36, 32'h80000000, 32'h0, 1'b0, 32'h08000000};
    v[11] = '{2'b10, F_SRAV, 32'd4, 32'h80000000, 32'h0, 1'b0, 32'hF8000000};
    v[12] = '{2'b11, 6'h00,  32'h10, 32'h0, 32'h1, 1'b1, 32'h11};
    v[13] = '{2'b10, 6'h3F,  32'd5, 32'd5, 32'h0, 1'b0, 32'h0};
    v[14] = '{2'b10, F_SUB,  32'd3, 32'd5, 32'h0, 1'b0, 32'hFFFFFFFE};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    ALUSrc = 1'b0; srcA = '0; srcB = '0; imm = '0;
    ALUOp = 2'b00; funct = '0;
    s_in_valid = 1'b0; s_ALUSrc = 1'b0; s_srcA = '0;
    s_srcB = '0; s_imm = '0; s_ALUOp = 2'b00; s_funct = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_alu", aluOut, 0);
    chk("rst_zf", zeroFlag, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_rdy", in_ready, 1);
    @(negedge clk); rst = 1'b0;

    foreach (v[i]) begin
      op(v[i].aop, v[i].fn, v[i].a, v[i].b, v[i].im, v[i].src, 1'b0);
      chk($sformatf("vec%0d_alu", i), aluOut, v[i].exp);
      chk($sformatf("vec%0d_zf", i), zeroFlag, v[i].exp == 0);
      chk($sformatf("vec%0d_ov", i), out_valid, 1);
    end
    @(negedge clk); @(posedge clk); #1;
    chk("idle_ov", out_valid, 0);
    chk("idle_hold", aluOut, 32'hFFFFFFFE);

    rop(F_MULT, 32'hFFFFFFFF, 32'd2);
    chk("mult_ov", out_valid, 1);
    chk("mult_alu", aluOut, 0);
    chk("mult_busy", md_busy, 1);
    wait_idle(n);
    chk("mult_stall", n, 32);
    rop(F_MFHI, 0, 0); chk("mult_hi", aluOut, 32'hFFFFFFFF);
    rop(F_MFLO, 0, 0); chk("mult_lo", aluOut, 32'hFFFFFFFE);

    rop(F_MULTU, 32'hFFFFFFFF, 32'd2); wait_idle(n);
    rop(F_MFHI, 0, 0); chk("multu_hi", aluOut, 32'h1);
    rop(F_MFLO, 0, 0); chk("multu_lo", aluOut, 32'hFFFFFFFE);

    rop(F_DIV, 32'd7, 32'hFFFFFFFE); wait_idle(n);
    rop(F_MFLO, 0, 0); chk("div_lo", aluOut, 32'hFFFFFFFD);
    rop(F_MFHI, 0, 0); chk("div_hi", aluOut, 32'h1);

    rop(F_DIV, 32'd9, 32'd0); wait_idle(n);
    rop(F_MFLO, 0, 0); chk("dz_lo", aluOut, 32'hFFFFFFFF);
    rop(F_MFHI, 0, 0); chk("dz_hi", aluOut, 32'd9);

    rop(F_DIV, 32'h80000000, 32'hFFFFFFFF); wait_idle(n);
    rop(F_MFLO, 0, 0); chk("ovf_lo", aluOut, 32'h80000000);
    rop(F_MFHI, 0, 0); chk("ovf_hi", aluOut, 32'h0);

    rop(F_MTHI, 32'hABCD, 0);
    chk("mthi_alu", aluOut, 0);
    chk("mthi_zf", zeroFlag, 1);
    rop(F_MFHI, 0, 0); chk("mthi_rd", aluOut, 32'hABCD);

    rop(F_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    ALUOp = 2'b10; funct = F_MFHI; in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("stall_ov", out_valid, 0);
    end while (!out_valid && n < 200);
    in_valid = 1'b0;
    chk("stall_edges", n, 33);
    chk("stall_hi", aluOut, 32'd2);
    rop(F_MFLO, 0, 0); chk("divu_lo", aluOut, 32'd14);

    op(2'b10, F_ADD, 32'd1, 32'd1, 32'h0, 1'b0, 1'b1);
    chk("flush_ov", out_valid, 0);
    chk("flush_hold", aluOut, 32'd14);

    rop(F_MULTU, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy", md_busy, 0);
    chk("mrst_rdy", in_ready, 1);
    chk("mrst_ov", out_valid, 0);
    chk("mrst_alu", aluOut, 0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("mrst_idle", md_busy, 0);
    rop(F_MFHI, 0, 0); chk("mrst_hi", aluOut, 0);
    rop(F_MFLO, 0, 0); chk("mrst_lo", aluOut, 0);

    op16(F_DIVU, 16'hFFFF, 16'd3);
    chk("x16_busy", s_md_busy, 1);
    n = 0;
    @(negedge clk);
    while (!s_in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("x16_stall", n, 16);
    op16(F_MFLO, 0, 0); chk("x16_lo", s_aluOut, 16'h5555);
    op16(F_MFHI, 0, 0); chk("x16_hi", s_aluOut, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
